pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Elastic pipeline-stage register for the stage boundaries of the core.
- Unlike the plain reset-to-value stage register, it is driven by a valid/ready handshake on both sides and holds data under downstream backpressure without loss.
- A 2-entry skid buffer (main + skid) keeps every output registered, so timing paths are cut in both directions and full throughput is preserved.
- A flush input kills in-flight entries on branch redirect or trap.

Parameters:
- DW, 32, payload width in bits.
- RST_VAL, {DW{1'b0}}, value m_data takes on reset and on flush (e.g. NOP encoding 32'h00000013 for an instruction stage).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- s_valid  input  1  upstream payload valid.
- s_ready  output  1  stage can accept; registered.
- s_data  input  DW  upstream payload.
- m_valid  output  1  downstream payload valid; registered.
- m_ready  input  1  downstream accepts.
- m_data  output  DW  downstream payload; registered.

Behaviour:
- Reset (rst high, async):
  - m_valid=0, m_data=RST_VAL, s_ready=1.
  - Skid entry empties; skid data resets to RST_VAL.
  - No capture occurs while rst is high, regardless of s_valid.
- Transfers:
  - Upstream transfer = s_valid & s_ready at posedge.
  - Downstream transfer = m_valid & m_ready at posedge.
- States:
  - EMPTY: main and skid empty.
  - ONE: main full, skid empty.
  - FULL: main and skid full.
- Transitions (flush low):
  - EMPTY + upstream transfer -> ONE; m_data<=s_data, m_valid<=1. Latency s_data->m_data is 1 cycle.
  - ONE, downstream transfer and upstream transfer -> ONE; m_data<=s_data. Full throughput of 1 word/cycle.
  - ONE, downstream transfer only -> EMPTY; m_valid<=0; m_data holds its last value.
  - ONE, upstream transfer only -> FULL; skid<=s_data, s_ready<=0.
  - FULL + downstream transfer -> ONE; m_data<=skid, s_ready<=1.
  - FULL, no downstream transfer -> hold. s_ready=0, so no upstream transfer is possible.
- Invariants:
  - s_ready == !skid_valid at all times.
  - Data ordering is strictly FIFO; no duplication, no drop.
  - m_data and m_valid must not change while m_valid=1 and m_ready=0, except on flush or reset.
- Flush:
  - Highest synchronous priority, over any concurrent transfer.
  - Next state is EMPTY: m_valid<=0, m_data<=RST_VAL, skid cleared, s_ready<=1.
  - An s_data presented in the flush cycle is dropped, even if s_ready=1.
- Reset mid-operation: asserting rst in any state returns immediately to reset values. Held data is discarded.
- m_ready is ignored when m_valid=0.
- s_data is ignored when s_valid=0.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Increments each cycle m_valid=1 and m_ready=0, saturating at 32'hFFFFFFFF.
  - Reset value 0; flush does not clear it.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RST_VAL=32'h13 -> m_valid=0, m_data=32'h13, s_ready=1 during rst and in the first cycle after release.
- Stream 8 words 0..7 with m_ready=1 constantly -> outputs 0..7 in consecutive cycles, each 1 cycle after input, s_ready stays 1.
- Send A=32'hA, B=32'hB with m_ready=0 -> after B, s_ready=0 and m_data=A held. Raise m_ready -> A then B delivered in order, s_ready back to 1 after A leaves.
- FULL with A/B held, assert flush together with m_ready=1 and s_valid=1 with C -> next cycle m_valid=0, m_data=RST_VAL, s_ready=1; A, B and C are never delivered.
- Assert rst asynchronously mid-cycle in FULL -> m_valid drops to 0 before the next edge; after release, new word D is delivered with no stale A/B.
- With PIPE_SKID_STALL_CNT_EN defined, hold m_valid=1 and m_ready=0 for 5 cycles -> stall_cnt=5, unchanged after a flush.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic stage register: main + skid entry, all outputs registered.
// Optional stall counter port enabled by PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] skid_data;
  logic          up;
  logic          dn;

  assign up = s_valid & s_ready;
  assign dn = m_valid & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      m_valid   <= 1'b0;
      m_data    <= RST_VAL;
      skid_data <= RST_VAL;
      s_ready   <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      m_valid   <= 1'b0;
      m_data    <= RST_VAL;
      skid_data <= RST_VAL;
      s_ready   <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (up) begin
            state   <= ONE;
            m_valid <= 1'b1;
            m_data  <= s_data;
          end
        end
        ONE: begin
          if (up && dn) begin
            m_data <= s_data;
          end else if (dn) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
          end else if (up) begin
            state     <= FULL;
            skid_data <= s_data;
            s_ready   <= 1'b0;
          end
        end
        FULL: begin
          // s_ready is low here, so only the drain side can move
          if (dn) begin
            state   <= ONE;
            m_data  <= skid_data;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (m_valid && !m_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
